fetch_prefetch: RTL and testbench

- Parametrised next-generation instruction fetch unit for the 17-bit processor.
- Drives an external single-port synchronous SRAM that is shared with data load/store traffic.
- Buffers fetched instructions in an internal show-ahead FIFO of configurable depth, tagging each with its address and a static branch prediction.
- Adds selectable prediction mode, in-flight read squash on restart, and credit-based flow control so the FIFO never overflows.

---
 rtl/fetch_prefetch_if.sv | 25 ++
 rtl/fetch_prefetch.sv | 145 ++++++++++++++
 tb/tb_fetch_prefetch.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_prefetch_if.sv
// SRAM port shared by instruction fetch and data load/store traffic.
// The master drives address/write controls; the SRAM returns read data one cycle later.
interface fetch_prefetch_if #(
  parameter int A_WIDTH = 10,
  parameter int I_WIDTH = 17
);
  logic [A_WIDTH-1:0] mem_addr_o;
  logic               mem_wren_o;
  logic [I_WIDTH-1:0] mem_wdata_o;
  logic [I_WIDTH-1:0] mem_rdata_i;

  modport master (
    output mem_addr_o,
    output mem_wren_o,
    output mem_wdata_o,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_addr_o,
    input  mem_wren_o,
    input  mem_wdata_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction prefetcher: credit-limited fetch into a show-ahead FIFO, static branch
// prediction on each returning word, restart squash, and data-access priority on the SRAM.
module fetch_prefetch #(
  parameter int          I_WIDTH    = 17,
  parameter int          A_WIDTH    = 10,
  parameter int          O_WIDTH    = 5,
  parameter int          FIFO_DEPTH = 4,
  parameter int          BP_MODE    = 2,
  parameter int unsigned RESET_ADDR = 0
) (
  input  logic               clk,
  input  logic               rst_n_i,
  input  logic               dequeue_i,
  input  logic               restart_i,
  input  logic [A_WIDTH-1:0] restart_addr_i,
  input  logic               load_store_valid_i,
  input  logic               store_en_i,
  input  logic [A_WIDTH-1:0] load_store_addr_i,
  input  logic [I_WIDTH-1:0] store_data_i,
  output logic [I_WIDTH-1:0] load_data_o,
  output logic               load_data_valid_o,
  fetch_prefetch_if.master   mem,
  output logic [I_WIDTH-1:0] instruction_data_o,
  output logic [A_WIDTH-1:0] instruction_addr_o,
  output logic               instruction_pred_o,
  output logic               instruction_valid_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [I_WIDTH-1:0] data;
    logic [A_WIDTH-1:0] addr;
    logic               pred;
  } entry_t;

  entry_t             fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [A_WIDTH-1:0] pc_r, pend_addr_r;
  logic               fetch_pend_r, load_pend_r;

  logic               ret, enq, deq, issue, ret_pred;
  logic [A_WIDTH-1:0] succ, fetch_addr;
  logic [CNT_W:0]     credit;
  entry_t             head;

  function automatic logic predict_taken(input logic [I_WIDTH-1:0] instr);
    logic signed [O_WIDTH-1:0] off;
    off = $signed(instr[O_WIDTH-1:0]);
    case (BP_MODE)
      1:       return instr[I_WIDTH-1];
      2:       return instr[I_WIDTH-1] && (off < 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [A_WIDTH-1:0] branch_target(input logic [A_WIDTH-1:0] base,
                                                       input logic [I_WIDTH-1:0] instr);
    logic signed [A_WIDTH-1:0] off_ext;
    off_ext = A_WIDTH'($signed(instr[O_WIDTH-1:0]));
    return base + $unsigned(off_ext);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // A return's successor can be issued in the same cycle, giving one fetch per cycle.
  assign ret        = fetch_pend_r;
  assign ret_pred   = predict_taken(mem.mem_rdata_i);
  assign succ       = ret_pred ? branch_target(pend_addr_r, mem.mem_rdata_i)
                               : pend_addr_r + A_WIDTH'(1);
  assign fetch_addr = ret ? succ : pc_r;

  // Outstanding fetch counts as an occupied slot so the FIFO can never overflow.
  assign credit = {1'b0, count_r} + {{CNT_W{1'b0}}, fetch_pend_r};
  assign issue  = !load_store_valid_i && !restart_i && (credit < DEPTH_C);
  assign enq    = ret && !restart_i;
  assign deq    = dequeue_i && (count_r != '0) && !restart_i;

  always_comb begin
    mem.mem_addr_o  = fetch_addr;
    mem.mem_wren_o  = 1'b0;
    mem.mem_wdata_o = '0;
    if (load_store_valid_i) begin
      mem.mem_addr_o  = load_store_addr_i;
      mem.mem_wren_o  = store_en_i;
      mem.mem_wdata_o = store_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pc_r         <= A_WIDTH'(RESET_ADDR);
      fetch_pend_r <= 1'b0;
      load_pend_r  <= 1'b0;
      count_r      <= '0;
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
    end else begin
      load_pend_r <= load_store_valid_i && !store_en_i;
      if (restart_i) begin
        count_r      <= '0;
        wr_ptr_r     <= '0;
        rd_ptr_r     <= '0;
        pc_r         <= restart_addr_i;
        fetch_pend_r <= 1'b0;
      end else begin
        if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
        if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
        case ({enq, deq})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
        if (issue) begin
          fetch_pend_r <= 1'b1;
          pc_r         <= fetch_addr;
        end else if (ret) begin
          fetch_pend_r <= 1'b0;
          pc_r         <= succ;
        end
      end
    end
  end

  // Storage is only ever read behind a valid count, so it carries no reset.
  always_ff @(posedge clk) begin
    if (issue) pend_addr_r <= fetch_addr;
    if (enq)   fifo_q[wr_ptr_r] <= '{data: mem.mem_rdata_i, addr: pend_addr_r, pred: ret_pred};
  end

  assign head                = fifo_q[rd_ptr_r];
  assign instruction_valid_o = (count_r != '0);
  assign instruction_data_o  = instruction_valid_o ? head.data : '0;
  assign instruction_addr_o  = instruction_valid_o ? head.addr : '0;
  assign instruction_pred_o  = instruction_valid_o && head.pred;
  assign load_data_valid_o   = load_pend_r;
  assign load_data_o         = load_pend_r ? mem.mem_rdata_i : '0;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed and randomized bench for fetch_prefetch with a program-flow reference model.
module tb_fetch_prefetch;
  localparam int IW = 17;
  localparam int AW = 10;
  localparam int BP = 2;

  logic          clk = 1'b0;
  logic          rst_n_i;
  logic          dequeue_i, restart_i, load_store_valid_i, store_en_i;
  logic [AW-1:0] restart_addr_i, load_store_addr_i;
  logic [IW-1:0] store_data_i, load_data_o, instruction_data_o;
  logic [AW-1:0] instruction_addr_o;
  logic          load_data_valid_o, instruction_pred_o, instruction_valid_o;

  int checks = 0;
  int errors = 0;
  int exp_next = 0;
  int delivered = 0;
  logic          ld_pend_m = 1'b0;
  logic [IW-1:0] ld_exp = '0;
  logic [IW-1:0] sram [1024];

  fetch_prefetch_if #(.A_WIDTH(AW), .I_WIDTH(IW)) bus ();

  fetch_prefetch #(.I_WIDTH(IW), .A_WIDTH(AW), .O_WIDTH(5), .FIFO_DEPTH(4),
                   .BP_MODE(BP), .RESET_ADDR(0)) dut (
    .clk                (clk),
    .rst_n_i            (rst_n_i),
    .dequeue_i          (dequeue_i),
    .restart_i          (restart_i),
    .restart_addr_i     (restart_addr_i),
    .load_store_valid_i (load_store_valid_i),
    .store_en_i         (store_en_i),
    .load_store_addr_i  (load_store_addr_i),
    .store_data_i       (store_data_i),
    .load_data_o        (load_data_o),
    .load_data_valid_o  (load_data_valid_o),
    .mem                (bus.master),
    .instruction_data_o (instruction_data_o),
    .instruction_addr_o (instruction_addr_o),
    .instruction_pred_o (instruction_pred_o),
    .instruction_valid_o(instruction_valid_o)
  );

  always #5 clk = ~clk;

  // Synchronous single-port SRAM: read data one cycle after the address.
  always @(posedge clk) begin
    if (bus.mem_wren_o) sram[bus.mem_addr_o] <= bus.mem_wdata_o;
    bus.mem_rdata_i <= sram[bus.mem_addr_o];
  end

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  function automatic int offset_of(input logic [IW-1:0] ins);
    int off;
    off = int'(ins[4:0]);
    if (off >= 16) off = off - 32;
    return off;
  endfunction

  function automatic logic pred_m(input logic [IW-1:0] ins);
    return ins[IW-1] && (BP == 1 || (BP == 2 && offset_of(ins) < 0));
  endfunction

  function automatic int succ_m(input int a, input logic [IW-1:0] ins);
    if (pred_m(ins)) return (a + offset_of(ins) + 1024) % 1024;
    return (a + 1) % 1024;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic [IW-1:0] ins;
    @(negedge clk);
    if (ld_pend_m) begin
      chk("load_valid", 32'(load_data_valid_o), 32'd1);
      chk("load_data", 32'(load_data_o), 32'(ld_exp));
    end else begin
      chk("load_idle", 32'(load_data_valid_o), 32'd0);
    end
    ld_pend_m = load_store_valid_i && !store_en_i;
    ld_exp    = sram[load_store_addr_i];
    if (restart_i) begin
      exp_next = int'(restart_addr_i);
    end else if (instruction_valid_o && dequeue_i) begin
      ins = sram[exp_next];
      chk("head_addr", 32'(instruction_addr_o), 32'(exp_next));
      chk("head_data", 32'(instruction_data_o), 32'(ins));
      chk("head_pred", 32'(instruction_pred_o), 32'(pred_m(ins)));
      exp_next = succ_m(exp_next, ins);
      delivered++;
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    sample();
    adv();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(instruction_valid_o), 32'd0);
    chk({tag, "_idata"}, 32'(instruction_data_o), 32'd0);
    chk({tag, "_iaddr"}, 32'(instruction_addr_o), 32'd0);
    chk({tag, "_ipred"}, 32'(instruction_pred_o), 32'd0);
    chk({tag, "_ldvld"}, 32'(load_data_valid_o), 32'd0);
    chk({tag, "_lddata"}, 32'(load_data_o), 32'd0);
    chk({tag, "_wren"}, 32'(bus.mem_wren_o), 32'd0);
    chk({tag, "_wdata"}, 32'(bus.mem_wdata_o), 32'd0);
  endtask

  function automatic logic [IW-1:0] rand_instr();
    logic p;
    p = ($urandom_range(99) < 30);
    return {p, 16'($urandom)};
  endfunction

  initial begin
    for (int i = 0; i < 1024; i++) sram[i] = IW'(i + 1);
    sram[10'h3FF] = 17'h00400;
    rst_n_i = 1'b1;
    dequeue_i = 1'b0; restart_i = 1'b0; restart_addr_i = '0;
    load_store_valid_i = 1'b0; store_en_i = 1'b0;
    load_store_addr_i = '0; store_data_i = '0;
    #1 rst_n_i = 1'b0;
    #1 check_reset_outputs("por");
    adv();
    adv();
    rst_n_i = 1'b1;

    // Fill with no consumption, then reset in the middle of fetching.
    sample();
    chk("first_fetch", 32'(bus.mem_addr_o), 32'h000);
    adv();
    for (int i = 0; i < 5; i++) step();
    #2 rst_n_i = 1'b0;
    #1 check_reset_outputs("midrst");
    exp_next = 0;
    ld_pend_m = 1'b0;
    adv();
    rst_n_i = 1'b1;
    dequeue_i = 1'b1;
    sample();
    chk("refetch_addr", 32'(bus.mem_addr_o), 32'h000);
    chk("refetch_wren", 32'(bus.mem_wren_o), 32'd0);
    adv();
    sample();
    chk("lat_empty", 32'(instruction_valid_o), 32'd0);
    adv();
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("stream_valid", 32'(instruction_valid_o), 32'd1);
      adv();
    end

    // Backward branch taken, forward branch not taken.
    restart_i = 1'b1; restart_addr_i = 10'h005; sram[5] = 17'h1001E;
    step();
    restart_i = 1'b0;
    sample(); chk("br_fetch5", 32'(bus.mem_addr_o), 32'h005); adv();
    sample(); chk("br_back_target", 32'(bus.mem_addr_o), 32'h003); adv();
    sample(); chk("br_pred1", 32'(instruction_pred_o), 32'd1); adv();
    restart_i = 1'b1; restart_addr_i = 10'h005; sram[5] = 17'h10002;
    step();
    restart_i = 1'b0;
    step();
    sample(); chk("br_fwd_next", 32'(bus.mem_addr_o), 32'h006); adv();
    sample(); chk("br_pred0", 32'(instruction_pred_o), 32'd0); adv();

    // Fill to depth with no consumption; one dequeue earns exactly one fetch.
    dequeue_i = 1'b0;
    restart_i = 1'b1; restart_addr_i = 10'h010;
    step();
    restart_i = 1'b0;
    for (int i = 0; i < 9; i++) step();
    sample(); chk("fill_head", 32'(instruction_addr_o), 32'h010); adv();
    dequeue_i = 1'b1;
    step();
    dequeue_i = 1'b0;
    sample(); chk("credit_fetch", 32'(bus.mem_addr_o), 32'h014); adv();
    for (int i = 0; i < 4; i++) step();
    dequeue_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample(); chk("drain_valid", 32'(instruction_valid_o), 32'd1); adv();
    end
    for (int i = 0; i < 4; i++) step();

    // Restart to the top of memory while a fetch returns and exec dequeues.
    restart_i = 1'b1; restart_addr_i = 10'h3FF;
    step();
    restart_i = 1'b0;
    sample();
    chk("rst_flush", 32'(instruction_valid_o), 32'd0);
    chk("rst_target", 32'(bus.mem_addr_o), 32'h3FF);
    adv();
    sample(); chk("wrap_fetch", 32'(bus.mem_addr_o), 32'h000); adv();
    sample(); chk("wrap_head", 32'(instruction_addr_o), 32'h3FF); adv();
    for (int i = 0; i < 3; i++) step();

    // Load over a pending fetch, then a store, then read the stored word.
    load_store_valid_i = 1'b1; store_en_i = 1'b0; load_store_addr_i = 10'h200;
    sample();
    chk("ld_addr", 32'(bus.mem_addr_o), 32'h200);
    chk("ld_wren", 32'(bus.mem_wren_o), 32'd0);
    adv();
    load_store_valid_i = 1'b0;
    sample(); chk("ld_result", 32'(load_data_o), 32'h00201); adv();
    step();
    load_store_valid_i = 1'b1; store_en_i = 1'b1;
    load_store_addr_i = 10'h201; store_data_i = 17'h1ABCD;
    sample();
    chk("st_wren", 32'(bus.mem_wren_o), 32'd1);
    chk("st_wdata", 32'(bus.mem_wdata_o), 32'h1ABCD);
    chk("st_addr", 32'(bus.mem_addr_o), 32'h201);
    adv();
    store_en_i = 1'b0;
    sample(); chk("st_one_cycle", 32'(bus.mem_wren_o), 32'd0); adv();
    load_store_valid_i = 1'b0;
    sample(); chk("st_readback", 32'(load_data_o), 32'h1ABCD); adv();
    for (int i = 0; i < 2; i++) step();

    // Restart and load in the same cycle.
    restart_i = 1'b1; restart_addr_i = 10'h040;
    load_store_valid_i = 1'b1; load_store_addr_i = 10'h200;
    sample(); chk("rl_addr", 32'(bus.mem_addr_o), 32'h200); adv();
    restart_i = 1'b0; load_store_valid_i = 1'b0;
    sample();
    chk("rl_fetch", 32'(bus.mem_addr_o), 32'h040);
    chk("rl_wren", 32'(bus.mem_wren_o), 32'd0);
    adv();
    sample(); chk("rl_next", 32'(bus.mem_addr_o), 32'h041); adv();

    // Random dequeue/restart/load traffic over a random program.
    for (int c = 0; c < 1500; c++) begin
      restart_i          = ($urandom_range(99) < 3);
      restart_addr_i     = AW'($urandom_range(1023));
      dequeue_i          = ($urandom_range(99) < 75);
      load_store_valid_i = ($urandom_range(99) < 10);
      store_en_i         = 1'b0;
      load_store_addr_i  = AW'($urandom_range(1023));
      if (restart_i)
        for (int i = 0; i < 1024; i++) sram[i] = rand_instr();
      sample();
      chk("rand_nostore", 32'(bus.mem_wren_o), 32'd0);
      adv();
    end
    restart_i = 1'b0; load_store_valid_i = 1'b0; dequeue_i = 1'b0;
    step();
    chk("progress", 32'(delivered > 200), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
